// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: the first differing bit pair decides GT/LT.
// o1/o2/o3 (GT/EQ/LT) are one-hot, registered, and held between words.
module serial_mag_comparator #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic o1,
  output logic o2,
  output logic o3
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {EQ, GT, LT} dec_t;

  state_t          state, state_nxt;
  dec_t            dec, dec_nxt;
  logic [CW-1:0]   cnt;
  logic            last_bit;

  always_comb begin
    dec_nxt = dec;
    if (dec == EQ) begin
      if (a_bit && !b_bit)
        dec_nxt = GT;
      else if (!a_bit && b_bit)
        dec_nxt = LT;
    end
  end

  assign last_bit = (state == SHIFT) && bit_valid && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results load on the edge that consumes the last bit, so they are valid during DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      dec <= EQ;
      o1  <= 1'b0;
      o2  <= 1'b1;
      o3  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            dec <= EQ;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            cnt <= cnt + CW'(1);
            dec <= dec_nxt;
          end
          if (last_bit) begin
            o1 <= (dec_nxt == GT);
            o2 <= (dec_nxt == EQ);
            o3 <= (dec_nxt == LT);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (W=4): hand-computed GT/EQ/LT results,
// done timing, stalls, mid-word reset and ignored start/bit_valid.
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  logic rst_n, start, bit_valid, a_bit, b_bit;
  logic busy, done, o1, o2, o3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [2:0]  prev_out;

  serial_mag_comparator #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
    .o1(o1), .o2(o2), .o3(o3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full word, MSB first; gap idle cycles before each bit; disturb injects
  // a start pulse mid-word and a bit_valid pulse in IDLE before the start.
  task automatic send_word(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input int unsigned gap, input bit disturb, input logic [2:0] exp);
    if (disturb) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      tick();
      bit_valid = 1'b0;
      check({tag, "_idle_bv_busy"}, busy, 1'b0);
      check({tag, "_idle_bv_out"}, {o1, o2, o3}, prev_out);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      for (int unsigned g = 0; g < gap; g++) begin
        tick();
        check({tag, "_stall_out"}, {busy, done, o1, o2, o3}, {2'b10, prev_out});
      end
      if (disturb && i == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_mid_start"}, {busy, done}, 2'b10);
      end
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      tick();
      bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      if (i > 0) check({tag, "_no_early_done"}, {busy, done, o1, o2, o3}, {2'b10, prev_out});
    end
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_result"}, {o1, o2, o3}, exp);
    tick();
    check({tag, "_after"}, {busy, done}, 2'b00);
    check({tag, "_held"}, {o1, o2, o3}, exp);
    prev_out = exp;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    prev_out = 3'b010;
    tick(); tick();
    check("reset_state", {busy, done, o1, o2, o3}, 5'b00010);
    rst_n = 1'b1;
    tick();

    send_word("eq_1010",  4'b1010, 4'b1010, 0, 1'b0, 3'b010);
    send_word("gt_lock",  4'b1000, 4'b0111, 0, 1'b0, 3'b100);
    send_word("lt_0011",  4'b0011, 4'b0101, 0, 1'b0, 3'b001);
    send_word("gt_stall", 4'b0110, 4'b0100, 3, 1'b0, 3'b100);

    // Mid-word reset after 2 bits of 1100/1100
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 3; i >= 2; i--) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_state", {busy, done, o1, o2, o3}, 5'b00010);
    rst_n = 1'b1;
    tick();
    check("midrst_no_done", {busy, done}, 2'b00);
    prev_out = 3'b010;
    send_word("post_rst", 4'b0001, 4'b0000, 0, 1'b0, 3'b100);

    // Reset wins over a simultaneous start
    rst_n = 1'b0; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    check("rst_prio", {busy, done, o1, o2, o3}, 5'b00010);
    prev_out = 3'b010;
    tick();
    check("rst_prio_idle", busy, 1'b0);

    send_word("disturb", 4'b0101, 4'b0110, 0, 1'b1, 3'b001);
    send_word("gap1_eq", 4'b1111, 4'b1111, 1, 1'b0, 3'b010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
